// File: rtl/prog_fetch_unit.sv
// prog_fetch_unit: program-memory byte fetcher feeding a prefetch FIFO.
// Optional IFU_BYPASS_EN: forward the in-flight byte when the FIFO is empty.
module prog_fetch_unit #(
    parameter int                   ADDRWIDTH    = 8,
    parameter int                   FIFO_DEPTH   = 4,
    parameter logic [ADDRWIDTH-1:0] RESET_VECTOR = '0
) (
    input  logic                 clk,
    input  logic                 rst,
    output logic                 mem_CS,
    output logic [ADDRWIDTH-1:0] mem_addr,
    input  logic [7:0]           mem_dout,
    input  logic                 jump,
    input  logic [ADDRWIDTH-1:0] jump_addr,
    output logic                 ib_valid,
    output logic [7:0]           ib_data,
    output logic [ADDRWIDTH-1:0] ib_pc,
    input  logic                 ib_ready
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_HOLD
    } state_t;

    state_t                 r_state;
    logic                   r_cs;
    logic [ADDRWIDTH-1:0]   r_addr;
    logic [ADDRWIDTH-1:0]   r_fetch_pc;
    logic                   r_inflight;
    logic [7:0]             r_data [FIFO_DEPTH];
    logic [ADDRWIDTH-1:0]   r_pc   [FIFO_DEPTH];
    logic [PW-1:0]          r_wptr;
    logic [PW-1:0]          r_rptr;
    logic [CW-1:0]          r_count;

    logic                   w_fifo_valid;
    logic [7:0]             w_head_data;
    logic [ADDRWIDTH-1:0]   w_head_pc;
    logic                   w_byp;
    logic                   w_pop;
    logic                   w_pop_fifo;
    logic                   w_push;
    logic [CW-1:0]          w_occ;
    logic                   w_issue;

    assign w_fifo_valid = (r_count != '0);
    assign w_head_data  = r_data[r_rptr];
    assign w_head_pc    = r_pc[r_rptr];

`ifdef IFU_BYPASS_EN
    // Empty FIFO with a byte on the bus: present the bus byte directly.
    assign w_byp    = (r_count == '0) & r_inflight & ~jump;
    assign ib_valid = w_fifo_valid | w_byp;
    assign ib_data  = w_byp ? mem_dout : w_head_data;
    assign ib_pc    = w_byp ? r_addr   : w_head_pc;
`else
    assign w_byp    = 1'b0;
    assign ib_valid = w_fifo_valid;
    assign ib_data  = w_head_data;
    assign ib_pc    = w_head_pc;
`endif

    assign mem_CS   = r_cs;
    assign mem_addr = r_addr;

    // A bypassed byte that is popped this cycle never enters the FIFO.
    assign w_pop      = ib_valid & ib_ready;
    assign w_pop_fifo = w_pop & ~w_byp;
    assign w_push     = r_inflight & ~(w_byp & ib_ready);

    // Occupancy after this edge; issue only if the issued byte will fit.
    assign w_occ   = r_count + CW'(w_push) - CW'(w_pop_fifo);
    assign w_issue = (w_occ < DEPTH_C);

    // Fetch FSM: drives the memory port and tracks the in-flight byte.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_cs       <= 1'b1;
            r_addr     <= RESET_VECTOR;
            r_fetch_pc <= RESET_VECTOR;
            r_inflight <= 1'b0;
        end else if (jump) begin
            r_state    <= S_RUN;
            r_cs       <= 1'b0;
            r_addr     <= jump_addr;
            r_fetch_pc <= jump_addr + ADDRWIDTH'(1);
            r_inflight <= 1'b1;
        end else begin
            if (w_issue) begin
                r_cs       <= 1'b0;
                r_addr     <= r_fetch_pc;
                r_fetch_pc <= r_fetch_pc + ADDRWIDTH'(1);
                r_inflight <= 1'b1;
            end else begin
                r_cs       <= 1'b1;
                r_inflight <= 1'b0;
            end
            unique case (r_state)
                S_IDLE:  r_state <= S_RUN;
                S_RUN:   r_state <= w_issue ? S_RUN : S_HOLD;
                S_HOLD:  r_state <= w_issue ? S_RUN : S_HOLD;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // FIFO pointers and occupancy; a jump empties it but keeps the head stable.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (jump) begin
            r_wptr  <= r_rptr;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + PW'(1);
            end
            if (w_pop_fifo) begin
                r_rptr <= r_rptr + PW'(1);
            end
            r_count <= w_occ;
        end
    end

    // FIFO storage: capture the returned byte with the address that fetched it.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_data[i] <= 8'h00;
                r_pc[i]   <= '0;
            end
        end else if (!jump && w_push) begin
            r_data[r_wptr] <= mem_dout;
            r_pc[r_wptr]   <= r_addr;
        end
    end

endmodule

// File: doc/prog_fetch_unit.md
# prog_fetch_unit

Instruction-byte fetch engine for the MCU51 core: the read-side initiator that drives the program-memory byte port (active-low chip select, address, byte data returned one negedge later) and streams fetched opcode/operand bytes into a small prefetch FIFO. The decoder pops bytes through a valid/ready handshake and redirects fetch on jumps. It sits between program memory and the instruction decoder.

## Interface
- ADDRWIDTH, 8, program address width
- FIFO_DEPTH, 4, prefetch entries (power of two, ≥2)
- RESET_VECTOR, 0, first fetch address after reset

- clk  in  1  clock; all state on posedge
- rst  in  1  synchronous, active-high reset
- mem_CS  out  1  program-memory chip select, L valid
- mem_addr  out  ADDRWIDTH  program-memory byte address
- mem_dout  in  8  program-memory read data (Z when CS high)
- jump  in  1  redirect request, sampled at posedge
- jump_addr  in  ADDRWIDTH  redirect target
- ib_valid  out  1  head FIFO entry valid
- ib_data  out  8  head byte
- ib_pc  out  ADDRWIDTH  address of head byte
- ib_ready  in  1  decoder pops head when ib_valid & ib_ready

## Operation
- Clocking/reset: one clock, clk; reset synchronous, active-high, port rst.
- Reset values: mem_CS=1, mem_addr=RESET_VECTOR, ib_valid=0, ib_data=8'h00, ib_pc=0, FIFO empty, inflight=0, state IDLE.
- States: IDLE → RUN on first posedge with rst=0 (issues RESET_VECTOR). RUN → HOLD when no issue possible (FIFO would overflow). HOLD → RUN when a pop frees space. Any state → IDLE on rst.
- Issue: at posedge, mem_CS←0, mem_addr←fetch_pc, fetch_pc←fetch_pc+1 (mod 2^ADDRWIDTH, FF→00 wraps) iff occupancy after this edge's push/pop < FIFO_DEPTH; else mem_CS←1, mem_addr held.
- Capture: inflight=1 means mem_CS was low last cycle; at posedge, push {mem_dout, mem_addr} into FIFO. mem_dout never sampled when inflight=0.
- Pop: ib_valid & ib_ready at posedge removes head; push and pop may coincide (occupancy unchanged).
- Jump: posedge with jump=1 clears FIFO, discards inflight byte, ignores ib_ready, issues jump_addr immediately (mem_CS←0, mem_addr←jump_addr, fetch_pc←jump_addr+1), state→RUN. Jump wins over every simultaneous event.
- jump while rst=1: ignored. jump in IDLE: target replaces RESET_VECTOR.
- ib_data/ib_pc are FIFO head; undefined-but-stable (hold last) when ib_valid=0.
- FIFO never overflows; occupancy ≤ FIFO_DEPTH by the issue rule.

## Timing
- mem_addr/mem_CS change only at posedge; memory latches at following negedge; byte captured at next posedge → issue-to-FIFO latency 1 cycle.
- Reset-release to first ib_valid: 2 posedges (IDLE issue edge, capture edge).
- Jump edge J: first target byte ib_valid=1 after edge J+1.
- Sustained throughput 1 byte/cycle while decoder pops every cycle.
- Full FIFO with ib_ready=0: mem_CS=1 steady; after one pop, reissue at that edge, byte lands next edge.

## Configuration
- IFU_BYPASS_EN defined: when FIFO empty, inflight=1 and no jump, ib_valid=1 combinationally with ib_data=mem_dout, ib_pc=mem_addr in the capture cycle; a pop that cycle consumes the byte and it is not pushed. Latency reset-release→ib_valid becomes 1 edge + half cycle.
- Undefined: all outputs purely registered from FIFO as above.

## Test plan
- Memory model 00:74,01:07,02:78,03:06; release rst, ib_ready=1 → bytes 74,07,78,06 with ib_pc 00..03 on consecutive cycles, first ib_valid after 2nd posedge.
- ib_ready=0 for 10 cycles → exactly FIFO_DEPTH=4 bytes buffered, mem_CS high from cycle 5, no byte lost; raise ib_ready → 74,07,78,06,… in order.
- jump=1, jump_addr=8'h10 with ib_ready=1 and inflight byte → popped byte that edge ignored, FIFO cleared, next ib_pc=10, no stale byte delivered.
- jump_addr=8'hFE → ib_pc sequence FE, FF, 00, 01 (wrap).
- rst asserted mid-stream for one cycle → ib_valid=0, mem_CS=1 next cycle; refetch resumes at RESET_VECTOR.
- Pop and capture on same edge with FIFO at depth-1 → occupancy unchanged, mem_CS stays low, no HOLD entry.
